rx_packet_decoder: RTL and testbench



---
 rtl/usb_rx_pkg.sv | 35 +++
 rtl/rx_packet_decoder.sv | 195 +++++++++++++++++++
 tb/tb_rx_packet_decoder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared PID codes, sync constant and decoder state encoding for the USB receive path.
package usb_rx_pkg;

    typedef enum logic [3:0] {
        PID_NONE  = 4'b0000,
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110,
        PID_DATA  = 4'b0011
    } pid_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_TOKEN,
        ST_HAND,
        ST_DATA,
        ST_ERR
    } state_t;

    // A PID byte carries its code in the low nibble and the complement in the high nibble.
    function automatic logic pid_is_valid(input logic [7:0] pid_byte);
        logic code_ok;
        case (pid_byte[3:0])
            PID_OUT, PID_IN, PID_ACK, PID_NAK, PID_STALL, PID_DATA: code_ok = 1'b1;
            default:                                                code_ok = 1'b0;
        endcase
        return code_ok && (pid_byte[7:4] == ~pid_byte[3:0]);
    endfunction

endpackage

// File: rtl/rx_packet_decoder.sv
// Classifies the received byte stream into PID codes, forwards DATA payload to the
// receive FIFO while withholding the two CRC bytes, latches token bytes, flags framing errors.
module rx_packet_decoder
    import usb_rx_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        byte_received,
    input  logic [7:0]  rcv_data,
    input  logic        eop,
    input  logic        fifo_full,
    output logic [3:0]  rx_packet,
    output logic        rx_transfer_active,
    output logic        rx_data_ready,
    output logic        rx_error,
    output logic        w_enable,
    output logic [7:0]  rx_packet_data,
    output logic        fifo_flush,
    output logic [15:0] rx_token
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_PAYLOAD);

    state_t      state_q, state_d;
    logic [3:0]  rx_packet_q, rx_packet_d;
    logic        active_q, active_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic        w_enable_q, w_enable_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        flush_q, flush_d;
    logic [15:0] token_q, token_d;
    logic [6:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  hold0_q, hold0_d;
    logic [7:0]  hold1_q, hold1_d;
    logic [1:0]  held_q, held_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            rx_packet_q <= PID_NONE;
            active_q    <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            w_enable_q  <= 1'b0;
            wdata_q     <= 8'h00;
            flush_q     <= 1'b0;
            token_q     <= 16'h0000;
            byte_cnt_q  <= 7'd0;
            hold0_q     <= 8'h00;
            hold1_q     <= 8'h00;
            held_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            rx_packet_q <= rx_packet_d;
            active_q    <= active_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            w_enable_q  <= w_enable_d;
            wdata_q     <= wdata_d;
            flush_q     <= flush_d;
            token_q     <= token_d;
            byte_cnt_q  <= byte_cnt_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            held_q      <= held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rx_packet_d = rx_packet_q;
        error_d     = error_q;
        wdata_d     = wdata_q;
        token_d     = token_q;
        byte_cnt_d  = byte_cnt_q;
        hold0_d     = hold0_q;
        hold1_d     = hold1_q;
        held_d      = held_q;
        w_enable_d  = 1'b0;
        ready_d     = 1'b0;
        flush_d     = 1'b0;

        if (byte_received) begin
            case (state_q)
                ST_IDLE: begin
                    if (rcv_data == SYNC_BYTE) begin
                        state_d     = ST_PID;
                        error_d     = 1'b0;
                        rx_packet_d = PID_NONE;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
                ST_PID: begin
                    if (pid_is_valid(rcv_data)) begin
                        rx_packet_d = rcv_data[3:0];
                        case (rcv_data[3:0])
                            PID_OUT, PID_IN: begin
                                state_d    = ST_TOKEN;
                                byte_cnt_d = 7'd0;
                            end
                            PID_DATA: begin
                                state_d    = ST_DATA;
                                byte_cnt_d = 7'd0;
                                held_d     = 2'd0;
                            end
                            default: state_d = ST_HAND;
                        endcase
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
                ST_TOKEN: begin
                    if (byte_cnt_q == 7'd2) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        if (byte_cnt_q == 7'd0) token_d[7:0] = rcv_data;
                        else                    token_d[15:8] = rcv_data;
                        byte_cnt_d = byte_cnt_q + 7'd1;
                    end
                end
                ST_HAND: begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end
                ST_DATA: begin
                    // The oldest held byte is known to be payload only once two newer bytes exist behind it.
                    if (held_q == 2'd2) begin
                        if (byte_cnt_q == MAX_CNT || fifo_full) begin
                            state_d = ST_ERR;
                            error_d = 1'b1;
                            flush_d = 1'b1;
                        end else begin
                            w_enable_d = 1'b1;
                            wdata_d    = hold0_q;
                            hold0_d    = hold1_q;
                            hold1_d    = rcv_data;
                            byte_cnt_d = byte_cnt_q + 7'd1;
                        end
                    end else if (held_q == 2'd1) begin
                        hold1_d = rcv_data;
                        held_d  = 2'd2;
                    end else begin
                        hold0_d = rcv_data;
                        held_d  = 2'd1;
                    end
                end
                default: ;
            endcase
        end

        // An eop that exposes a framing error also ends the packet, so it returns straight to IDLE.
        if (eop) begin
            case (state_d)
                ST_PID: begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                end
                ST_TOKEN: begin
                    if (byte_cnt_d != 7'd2) error_d = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_DATA: begin
                    if (held_d == 2'd2) begin
                        ready_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        flush_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                ST_HAND, ST_ERR: state_d = ST_IDLE;
                default: ;
            endcase
        end

        active_d = (state_d != ST_IDLE);
    end

    assign rx_packet          = rx_packet_q;
    assign rx_transfer_active = active_q;
    assign rx_data_ready      = ready_q;
    assign rx_error           = error_q;
    assign w_enable           = w_enable_q;
    assign rx_packet_data     = wdata_q;
    assign fifo_flush         = flush_q;
    assign rx_token           = token_q;

endmodule

// File: tb/tb_rx_packet_decoder.sv
// Directed and randomized packets for rx_packet_decoder, checked against a packet-level outcome model.
module tb_rx_packet_decoder;

    localparam int MAX_PAYLOAD = 64;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        byte_received;
    logic [7:0]  rcv_data;
    logic        eop;
    logic        fifo_full;
    logic [3:0]  rx_packet;
    logic        rx_transfer_active;
    logic        rx_data_ready;
    logic        rx_error;
    logic        w_enable;
    logic [7:0]  rx_packet_data;
    logic        fifo_flush;
    logic [15:0] rx_token;

    int checks = 0;
    int errors = 0;

    logic [7:0] obs_q[$];
    int         ready_cnt = 0;
    int         flush_cnt = 0;

    logic [7:0]  exp_q[$];
    int          exp_ready;
    int          exp_flush;
    logic [3:0]  m_packet = 4'h0;
    logic [15:0] m_token  = 16'h0000;
    logic        m_error  = 1'b0;

    logic [3:0] codes[6] = '{4'b0001, 4'b1001, 4'b0010, 4'b1010, 4'b1110, 4'b0011};

    rx_packet_decoder #(.MAX_PAYLOAD(MAX_PAYLOAD)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .byte_received      (byte_received),
        .rcv_data           (rcv_data),
        .eop                (eop),
        .fifo_full          (fifo_full),
        .rx_packet          (rx_packet),
        .rx_transfer_active (rx_transfer_active),
        .rx_data_ready      (rx_data_ready),
        .rx_error           (rx_error),
        .w_enable           (w_enable),
        .rx_packet_data     (rx_packet_data),
        .fifo_flush         (fifo_flush),
        .rx_token           (rx_token)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_enable) obs_q.push_back(rx_packet_data);
        if (rx_data_ready) ready_cnt++;
        if (fifo_flush) flush_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One cycle of inputs; optionally checks that a packet is in progress before driving.
    task automatic applyStimulus(input logic bv, input logic [7:0] d, input logic e, input logic chk_active);
        @(negedge clk);
        if (chk_active) checkOutput("active_mid", 32'(rx_transfer_active), 32'd1);
        byte_received = bv;
        rcv_data      = d;
        eop           = e;
    endtask

    function automatic logic validPid(input logic [7:0] b);
        logic [3:0] lo;
        lo = b[3:0];
        return (b[7:4] == ~lo) &&
               (lo == 4'b0001 || lo == 4'b1001 || lo == 4'b0010 ||
                lo == 4'b1010 || lo == 4'b1110 || lo == 4'b0011);
    endfunction

    // Outcome of a whole packet from the protocol rules alone.
    task automatic modelPacket(input logic [7:0] p[$], input logic full);
        int n;
        int m;
        int pay;
        logic [3:0] code;
        n = p.size();
        exp_q.delete();
        exp_ready = 0;
        exp_flush = 0;
        if (n == 0) return;
        if (p[0] != 8'h80) begin
            m_error = 1'b1;
            return;
        end
        m_packet = 4'h0;
        m_error  = 1'b0;
        if (n < 2 || !validPid(p[1])) begin
            m_error = 1'b1;
            return;
        end
        code     = p[1][3:0];
        m_packet = code;
        if (code == 4'b0001 || code == 4'b1001) begin
            if (n >= 3) m_token[7:0]  = p[2];
            if (n >= 4) m_token[15:8] = p[3];
            if (n != 4) m_error = 1'b1;
        end else if (code == 4'b0011) begin
            m = n - 2;
            if (m < 2) begin
                m_error = 1'b1;
                exp_flush = 1;
            end else begin
                pay = m - 2;
                if (full && pay > 0) begin
                    m_error = 1'b1;
                    exp_flush = 1;
                end else if (pay > MAX_PAYLOAD) begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) exp_q.push_back(p[2 + i]);
                    m_error = 1'b1;
                    exp_flush = 1;
                end else begin
                    for (int i = 0; i < pay; i++) exp_q.push_back(p[2 + i]);
                    exp_ready = 1;
                end
            end
        end else begin
            if (n != 2) m_error = 1'b1;
        end
    endtask

    task automatic sendPacket(input logic [7:0] p[$], input logic merge, input logic full);
        int n;
        n = p.size();
        obs_q.delete();
        ready_cnt = 0;
        flush_cnt = 0;
        fifo_full = full;
        modelPacket(p, full);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, p[i], merge && (i == n - 1), 1'b0);
            if (!(merge && i == n - 1))
                repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        end
        if (!merge) applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("active_fall", 32'(rx_transfer_active), 32'd0);
        repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        fifo_full = 1'b0;
        checkOutput("ready", 32'(ready_cnt), 32'(exp_ready));
        checkOutput("flush", 32'(flush_cnt), 32'(exp_flush));
        checkOutput("nwrites", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            checkOutput("wdata", 32'(obs_q[i]), 32'(exp_q[i]));
        checkOutput("rx_error", 32'(rx_error), 32'(m_error));
        checkOutput("rx_packet", 32'(rx_packet), 32'(m_packet));
        checkOutput("rx_token", 32'(rx_token), 32'(m_token));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_packet"}, 32'(rx_packet), 32'd0);
        checkOutput({tag, "_active"}, 32'(rx_transfer_active), 32'd0);
        checkOutput({tag, "_ready"}, 32'(rx_data_ready), 32'd0);
        checkOutput({tag, "_error"}, 32'(rx_error), 32'd0);
        checkOutput({tag, "_wen"}, 32'(w_enable), 32'd0);
        checkOutput({tag, "_wdata"}, 32'(rx_packet_data), 32'd0);
        checkOutput({tag, "_flush"}, 32'(fifo_flush), 32'd0);
        checkOutput({tag, "_token"}, 32'(rx_token), 32'd0);
    endtask

    function automatic logic [7:0] pidByte(input logic [3:0] c);
        return {~c, c};
    endfunction

    initial begin
        logic [7:0] pkt[$];
        int kind;
        int len;
        logic full;
        logic [7:0] b;

        byte_received = 1'b0;
        rcv_data      = 8'h00;
        eop           = 1'b0;
        fifo_full     = 1'b0;
        n_rst         = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        checkResetValues("reset");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        pkt = '{8'h80, 8'hD2};
        sendPacket(pkt, 1'b0, 1'b0);
        pkt = '{8'h80, 8'hC3, 8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB};
        sendPacket(pkt, 1'b0, 1'b0);
        pkt = '{8'h80, 8'h12, 8'h55, 8'h66};
        sendPacket(pkt, 1'b0, 1'b0);
        pkt = '{8'h80, 8'hE1, 8'h05};
        sendPacket(pkt, 1'b0, 1'b0);
        pkt = '{8'h80, 8'hE1, 8'h05, 8'h28};
        sendPacket(pkt, 1'b1, 1'b0);
        pkt = '{8'h80, 8'hC3};
        for (int i = 0; i < 67; i++) pkt.push_back(8'(i + 1));
        sendPacket(pkt, 1'b0, 1'b0);
        pkt = '{8'h80, 8'hC3};
        for (int i = 0; i < 66; i++) pkt.push_back(8'(i + 7));
        sendPacket(pkt, 1'b0, 1'b0);

        // Reset in the middle of a DATA packet after some payload has been written.
        pkt = '{8'h80, 8'hC3, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        obs_q.delete();
        flush_cnt = 0;
        foreach (pkt[i]) applyStimulus(1'b1, pkt[i], 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        checkResetValues("midrst");
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        checkOutput("midrst_noflush", 32'(flush_cnt), 32'd0);
        m_packet = 4'h0;
        m_token  = 16'h0000;
        m_error  = 1'b0;
        pkt = '{8'h80, 8'hD2};
        sendPacket(pkt, 1'b0, 1'b0);

        for (int k = 0; k < 80; k++) begin
            kind = $urandom_range(0, 9);
            full = 1'b0;
            pkt = '{8'h80};
            case (kind)
                0: begin
                    pkt.push_back(pidByte(codes[$urandom_range(0, 1)]));
                    repeat (2) pkt.push_back(8'($urandom));
                end
                1: begin
                    pkt.push_back(pidByte(codes[$urandom_range(0, 1)]));
                    len = $urandom_range(0, 1) ? 3 : $urandom_range(0, 1);
                    repeat (len) pkt.push_back(8'($urandom));
                end
                2: pkt.push_back(pidByte(codes[$urandom_range(2, 4)]));
                3: begin
                    pkt.push_back(pidByte(codes[$urandom_range(2, 4)]));
                    pkt.push_back(8'($urandom));
                end
                4, 5: begin
                    pkt.push_back(pidByte(4'b0011));
                    repeat ($urandom_range(0, 10)) pkt.push_back(8'($urandom));
                end
                6: begin
                    pkt.push_back(pidByte(4'b0011));
                    repeat ($urandom_range(62, 68)) pkt.push_back(8'($urandom));
                end
                7: begin
                    b = 8'($urandom);
                    if (b == 8'h80) b = 8'h81;
                    pkt[0] = b;
                    repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
                end
                8: begin
                    pkt.push_back(8'($urandom));
                    repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
                end
                default: begin
                    pkt.push_back(pidByte(4'b0011));
                    repeat ($urandom_range(0, 6)) pkt.push_back(8'($urandom));
                    full = 1'b1;
                end
            endcase
            sendPacket(pkt, 1'($urandom_range(0, 1)), full);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
